// File: rtl/mult_hilo_unit_pkg.sv
// Shared constants for the EX-stage multiplier: ALU control codes, FSM encoding, step count.
// Build option: MULT_RADIX4_EN selects the 2-bits-per-step datapath.
package mult_hilo_unit_pkg;

  localparam logic [5:0] ALU_AND   = 6'h00;
  localparam logic [5:0] ALU_OR    = 6'h01;
  localparam logic [5:0] ALU_ADD   = 6'h02;
  localparam logic [5:0] ALU_SUB   = 6'h06;
  localparam logic [5:0] ALU_SLT   = 6'h07;
  localparam logic [5:0] ALU_MULTU = 6'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

`ifdef MULT_RADIX4_EN
  localparam int MULT_BITS_PER_STEP = 2;
`else
  localparam int MULT_BITS_PER_STEP = 1;
`endif

  localparam int MULT_STEPS = 32 / MULT_BITS_PER_STEP;

  function automatic int mult_steps(input int width);
    return width / MULT_BITS_PER_STEP;
  endfunction

endpackage

// File: rtl/mult_hilo_unit_if.sv
// EX-stage bus between the pipeline (master) and the HI/LO multiplier (slave).
interface mult_hilo_if #(parameter int WIDTH = 32);
  logic [5:0]       ALUctrl;
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             mfhi;
  logic             mflo;
  logic [WIDTH-1:0] result;
  logic             stall;
  logic             busy;
  logic             done;

  modport master (
    output ALUctrl, start, opA, opB, mfhi, mflo,
    input  result, stall, busy, done
  );

  modport slave (
    input  ALUctrl, start, opA, opB, mfhi, mflo,
    output result, stall, busy, done
  );
endinterface

// File: rtl/mult_hilo_unit_step.sv
// One combinational add-and-shift iteration of the multiplier.
// MULT_RADIX4_EN: consume two multiplier bits per step using a precomputed 3A.
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] a,
`ifdef MULT_RADIX4_EN
  input  logic [WIDTH+1:0] a3,
`endif
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;

  always_comb begin
    addend = '0;
    case (acc_lo[1:0])
      2'd1:    addend = {2'b00, a};
      2'd2:    addend = {1'b0, a, 1'b0};
      2'd3:    addend = a3;
      default: addend = '0;
    endcase
    sum = {2'b00, acc_hi} + addend;
  end

  // acc_hi < 2^W and addend <= 3A, so the sum always fits in W+2 bits
  assign {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:2]};
`else
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a} : '0);
  end

  assign {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mult_hilo_unit.sv
// Iterative unsigned multiplier with architectural HI/LO, stalling dependent HI/LO accesses.
// Build option: MULT_RADIX4_EN halves the step count (see mult_step).
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mult_hilo_if.slave  bus
);

  localparam int STEPS = mult_steps(WIDTH);
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] a3_q, a3_d;
`endif

  logic [WIDTH-1:0] step_hi, step_lo;
  logic             launch;
  logic             last_step;

  assign launch    = bus.start && (bus.ALUctrl == ALU_MULTU);
  assign last_step = (cnt_q == CNT_LAST);

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .a      (a_q),
`ifdef MULT_RADIX4_EN
    .a3     (a3_q),
`endif
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = launch ? ST_RUN : ST_IDLE;
      ST_RUN:           state_d = last_step ? ST_DONE : ST_RUN;
      default:          state_d = ST_IDLE;
    endcase
  end

  // datapath next values
  always_comb begin
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULT_RADIX4_EN
    a3_d     = a3_q;
`endif
    if (state_q == ST_RUN) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
      if (last_step) begin
        hi_d = step_hi;
        lo_d = step_lo;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (launch) begin
      a_d      = bus.opA;
      acc_hi_d = '0;
      acc_lo_d = bus.opB;
      cnt_d    = '0;
`ifdef MULT_RADIX4_EN
      a3_d     = {2'b00, bus.opA} + {1'b0, bus.opA, 1'b0};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_RADIX4_EN
      a3_q     <= '0;
`endif
    end else begin
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULT_RADIX4_EN
      a3_q     <= a3_d;
`endif
    end
  end

  // outputs: a launch seen in RUN is held off until the DONE cycle
  always_comb begin
    bus.busy   = (state_q == ST_RUN);
    bus.done   = (state_q == ST_DONE);
    bus.stall  = (state_q == ST_RUN) && (bus.mfhi || bus.mflo || launch);
    bus.result = bus.mfhi ? hi_q : (bus.mflo ? lo_q : '0);
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scoreboarded bench for mult_hilo_unit: expected products queued at launch, checked at done.
module tb_mult_hilo_unit;

`ifdef MULT_RADIX4_EN
  localparam int STEPS = 16;
`else
  localparam int STEPS = 32;
`endif
  localparam logic [5:0] MULTU = 6'h13;

  logic clk = 1'b0;
  logic reset;
  int   chk = 0;
  int   errs = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi, last_lo;

  mult_hilo_if #(.WIDTH(32)) bus ();

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.ALUctrl = MULTU;
    bus.opA     = a;
    bus.opB     = b;
    exp_q.push_back({32'h0, a} * {32'h0, b});
    @(negedge clk);
    bus.start   = 1'b0;
    bus.ALUctrl = 6'h00;
  endtask

  task automatic wait_done(output int cyc, output int busy_n, output bit ok);
    cyc = 0; busy_n = 0; ok = 1'b0;
    while (cyc < STEPS + 8) begin
      #1;
      if (bus.done) begin ok = 1'b1; break; end
      if (bus.busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.mfhi = 1'b1; bus.mflo = 1'b0; #1 hi = bus.result;
    bus.mfhi = 1'b0; bus.mflo = 1'b1; #1 lo = bus.result;
    bus.mflo = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    bus.start = 0; bus.ALUctrl = 0; bus.opA = 0; bus.opB = 0; bus.mfhi = 0; bus.mflo = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    chk++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", bus.done); end
    chk++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    chk++; if (bus.result !== 32'h0) begin errs++; $display("FAIL reset_result got %h want 0", bus.result); end
    read_hilo(hi, lo);
    chk++; if (hi !== 32'h0 || lo !== 32'h0) begin errs++; $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_mult(input string name, input logic [31:0] a, input logic [31:0] b);
    int cyc, busy_n; bit ok;
    logic [31:0] hi, lo;
    logic [63:0] e;
    launch(a, b);
    wait_done(cyc, busy_n, ok);
    e = exp_q.pop_front();
    chk++; if (!ok) begin errs++; $display("FAIL %s_done_timeout got none want done after %0d", name, STEPS); end
    chk++; if (busy_n != STEPS) begin errs++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_n, STEPS); end
    read_hilo(hi, lo);
    chk++; if ({hi, lo} !== e) begin errs++; $display("FAIL %s_product got %h_%h want %h", name, hi, lo, e); end
    bus.mfhi = 1'b1; bus.mflo = 1'b1; #1;
    chk++; if (bus.result !== e[63:32]) begin errs++; $display("FAIL %s_hi_priority got %h want %h", name, bus.result, e[63:32]); end
    bus.mfhi = 1'b0; bus.mflo = 1'b0;
    last_hi = e[63:32]; last_lo = e[31:0];
    @(negedge clk); #1;
    chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL %s_done_pulse got done=%b busy=%b want 0 0", name, bus.done, bus.busy); end
  endtask

  task automatic test_stall();
    int n = 0;
    logic [63:0] e;
    launch(32'h10000, 32'h10000);
    #1;
    chk++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL stall_idle_run got %b want 0", bus.stall); end
    repeat (2) @(negedge clk);
    bus.mfhi = 1'b1;
    while (n < STEPS + 4) begin
      #1;
      if (!bus.busy) break;
      chk++; if (bus.stall !== 1'b1) begin errs++; $display("FAIL stall_run_cycle got %b want 1 at %0d", bus.stall, n); end
      n++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk++; if (n != STEPS - 2) begin errs++; $display("FAIL stall_cycles got %0d want %0d", n, STEPS - 2); end
    chk++; if (bus.done !== 1'b1 || bus.stall !== 1'b0) begin errs++; $display("FAIL stall_release got done=%b stall=%b want 1 0", bus.done, bus.stall); end
    chk++; if (bus.result !== e[63:32]) begin errs++; $display("FAIL stall_result got %h want %h", bus.result, e[63:32]); end
    bus.mfhi = 1'b0;
    last_hi = e[63:32]; last_lo = e[31:0];
    @(negedge clk);
  endtask

  task automatic test_ignore();
    logic [31:0] hi, lo;
    bus.start = 1'b1; bus.ALUctrl = 6'h02; bus.opA = 32'hDEAD; bus.opB = 32'hBEEF;
    repeat (3) begin
      @(negedge clk); #1;
      chk++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0)
        begin errs++; $display("FAIL ignore_state got busy=%b stall=%b done=%b want 0 0 0", bus.busy, bus.stall, bus.done); end
    end
    bus.start = 1'b0; bus.ALUctrl = 6'h00;
    read_hilo(hi, lo);
    chk++; if (hi !== last_hi || lo !== last_lo) begin errs++; $display("FAIL ignore_hilo got %h_%h want %h_%h", hi, lo, last_hi, last_lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    bit seen = 1'b0;
    launch(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    #1;
    chk++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rmid_busy got %b want 1", bus.busy); end
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errs++; $display("FAIL rmid_state got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    read_hilo(hi, lo);
    chk++; if (hi !== 32'h0 || lo !== 32'h0) begin errs++; $display("FAIL rmid_hilo got %h_%h want 0_0", hi, lo); end
    repeat (STEPS + 2) begin
      @(negedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    chk++; if (seen) begin errs++; $display("FAIL rmid_no_done got done want none"); end
    @(negedge clk);
    test_mult("rmid_relaunch", 32'd7, 32'd9);
    chk++; if (last_lo !== 32'h3F) begin errs++; $display("FAIL rmid_lo_ref got %h want 3f", last_lo); end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_n; bit ok;
    logic [31:0] hi, lo;
    logic [63:0] e;
    launch(32'd11, 32'd13);
    wait_done(cyc, busy_n, ok);
    e = exp_q.pop_front();
    chk++; if (!ok) begin errs++; $display("FAIL b2b_first_timeout got none want done"); end
    read_hilo(hi, lo);
    chk++; if ({hi, lo} !== e) begin errs++; $display("FAIL b2b_first got %h_%h want %h", hi, lo, e); end
    bus.start = 1'b1; bus.ALUctrl = MULTU; #1;
    chk++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL b2b_done_stall got %b want 0", bus.stall); end
    launch(32'd7, 32'd6);
    #1;
    chk++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
    wait_done(cyc, busy_n, ok);
    e = exp_q.pop_front();
    chk++; if (!ok || cyc + 1 != STEPS + 1) begin errs++; $display("FAIL b2b_latency got %0d want %0d", cyc + 1, STEPS + 1); end
    read_hilo(hi, lo);
    chk++; if ({hi, lo} !== e || lo !== 32'h2A) begin errs++; $display("FAIL b2b_second got %h_%h want %h", hi, lo, e); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_mult("m3x5", 32'd3, 32'd5);
    chk++; if (last_hi !== 32'h0 || last_lo !== 32'hF) begin errs++; $display("FAIL m3x5_ref got %h_%h want 0_f", last_hi, last_lo); end
    test_mult("mmax", 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk++; if (last_hi !== 32'hFFFFFFFE || last_lo !== 32'h1) begin errs++; $display("FAIL mmax_ref got %h_%h want fffffffe_1", last_hi, last_lo); end
    test_stall();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    for (int i = 0; i < 4; i++) test_mult("rand", $urandom, $urandom);
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
